// File: rtl/instr_encoder_if.sv
// Request and memory-write bus of the instruction encoder.
// master drives requests and accepts writes; slave is the encoder.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_cls;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [2:0]        req_funct3;
  logic              req_f7b5;
  logic [20:0]       req_imm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ready;

  modport master (
    output req_valid, req_cls, req_rd, req_rs1, req_rs2, req_funct3, req_f7b5, req_imm,
    output wr_ready,
    input  req_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_cls, req_rd, req_rs1, req_rs2, req_funct3, req_f7b5, req_imm,
    input  wr_ready,
    output req_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder feeding a FIFO that writes words to consecutive memory addresses.
// Optional ENC_ILLEGAL_NOP_EN: illegal requests push a NOP instead of being dropped.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  instr_encoder_if.slave           bus,
  input  logic                     restart,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_BRANCH = 7'b1100011,
    OP_IALU   = 7'b0010011,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic {IDLE, WRITE} state_e;

  state_e            state_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              err_q;
  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [FILL_W-1:0] fill_q, fill_d;

  logic [31:0] enc_word, push_word;
  logic        illegal, i_fits, b_fits;
  logic        accept, push, pop;
  logic [20:0] imm;

  always_comb begin
    imm      = bus.req_imm;
    // Sign bits above the field width must all match the field's top bit
    i_fits   = (imm[20:11] == {10{imm[11]}});
    b_fits   = (imm[20:12] == {9{imm[12]}}) && !imm[0];
    enc_word = '0;
    illegal  = 1'b0;
    unique case (bus.req_cls)
      3'd0: begin
        enc_word = {imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, OP_LOAD};
        illegal  = !i_fits;
      end
      3'd1: begin
        enc_word = {imm[11:5], bus.req_rs2, bus.req_rs1, bus.req_funct3, imm[4:0], OP_STORE};
        illegal  = !i_fits;
      end
      3'd2: begin
        enc_word = {1'b0, bus.req_f7b5, 5'b00000, bus.req_rs2, bus.req_rs1, bus.req_funct3,
                    bus.req_rd, OP_RTYPE};
      end
      3'd3: begin
        enc_word = {imm[12], imm[10:5], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                    imm[4:1], imm[11], OP_BRANCH};
        illegal  = !b_fits;
      end
      3'd4: begin
        enc_word = {imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, OP_IALU};
        illegal  = !i_fits;
      end
      3'd5: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.req_rd, OP_JAL};
        illegal  = imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign accept = bus.req_valid && bus.req_ready;
  assign pop    = wr_en_q && bus.wr_ready;

`ifdef ENC_ILLEGAL_NOP_EN
  assign push_word = illegal ? 32'h0000_0013 : enc_word;
  assign push      = accept;
`else
  assign push_word = enc_word;
  assign push      = accept && !illegal;
`endif

  always_comb begin
    fill_d = fill_q;
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fill_q <= fill_d;
      err_q  <= accept && illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE;
      wr_data_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fill_q != '0) begin
            state_q   <= WRITE;
            wr_en_q   <= 1'b1;
            wr_data_q <= mem_q[rd_ptr_q];
          end else if (restart && !accept) begin
            wr_addr_q <= BASE;
          end
        end
        WRITE: begin
          if (bus.wr_ready) begin
            wr_addr_q <= wr_addr_q + ADDR_W'(4);
            // With more than one entry the next head is already valid behind the current one
            if (fill_q > FILL_W'(1)) begin
              wr_data_q <= mem_q[rd_ptr_q + PTR_W'(1)];
            end else begin
              state_q <= IDLE;
              wr_en_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = (fill_q < FULL);
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign err           = err_q;
  assign fill          = fill_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed spec sequences plus randomized traffic against a field-arithmetic model.
module tb_instr_encoder;

  logic clk;
  logic rst_n, rst2_n, restart, restart2, err, err2;
  logic [2:0] fill, fill2;

  instr_encoder_if #(.ADDR_W(32)) bus ();
  instr_encoder_if #(.ADDR_W(4))  bus2 ();

  instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .restart(restart), .err(err), .fill(fill)
  );

  instr_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(12)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2), .restart(restart2), .err(err2), .fill(fill2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {illegal, word}; word is what the FIFO should receive
  function automatic logic [32:0] model_enc(input logic [2:0] cls, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5,
      input logic [20:0] imm);
    int v, w, base;
    bit ill;
    v    = int'($signed(imm));
    base = (int'(rs1) << 15) | (int'(f3) << 12);
    w    = 0;
    ill  = 1'b0;
    case (cls)
      3'd0: begin
        ill = (v < -2048) || (v > 2047);
        w = ((v & 'hFFF) << 20) | base | (int'(rd) << 7) | 'h03;
      end
      3'd1: begin
        ill = (v < -2048) || (v > 2047);
        w = (((v >> 5) & 'h7F) << 25) | (int'(rs2) << 20) | base | ((v & 'h1F) << 7) | 'h23;
      end
      3'd2: w = (int'(f7b5) << 30) | (int'(rs2) << 20) | base | (int'(rd) << 7) | 'h33;
      3'd3: begin
        ill = (v < -4096) || (v > 4094) || (v % 2 != 0);
        w = (((v >> 12) & 1) << 31) | (((v >> 5) & 'h3F) << 25) | (int'(rs2) << 20) | base |
            (((v >> 1) & 'hF) << 8) | (((v >> 11) & 1) << 7) | 'h63;
      end
      3'd4: begin
        ill = (v < -2048) || (v > 2047);
        w = ((v & 'hFFF) << 20) | base | (int'(rd) << 7) | 'h13;
      end
      3'd5: begin
        ill = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
        w = (((v >> 20) & 1) << 31) | (((v >> 1) & 'h3FF) << 21) | (((v >> 11) & 1) << 20) |
            (((v >> 12) & 'hFF) << 12) | (int'(rd) << 7) | 'h6F;
      end
      default: ill = 1'b1;
    endcase
    if (ill) w = 'h13;
    return {ill, w};
  endfunction

  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  wr_t         log1[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;
  logic        exp_err;
  logic [3:0]  log2[$];

  always @(negedge clk) begin
    logic [32:0] m;
    logic acc;
    int sz;
    if (rst_n !== 1'b1) begin
      exp_q.delete();
      exp_addr = '0;
      exp_err  = 1'b0;
    end else begin
      sz = exp_q.size();
      check("fill", fill, sz);
      check("req_ready", bus.req_ready, sz < 4);
      check("err", err, exp_err);
      if (bus.wr_en === 1'b1) begin
        check("wr_en_has_data", sz != 0, 1);
        if (sz != 0) begin
          check("wr_addr", bus.wr_addr, exp_addr);
          check("wr_data", bus.wr_data, exp_q[0]);
          if (bus.wr_ready) begin
            log1.push_back('{addr: bus.wr_addr, data: bus.wr_data});
            void'(exp_q.pop_front());
            exp_addr = exp_addr + 4;
          end
        end
      end
      acc = bus.req_valid && (sz < 4);
      m = model_enc(bus.req_cls, bus.req_rd, bus.req_rs1, bus.req_rs2, bus.req_funct3,
                    bus.req_f7b5, bus.req_imm);
      exp_err = acc && m[32];
`ifdef ENC_ILLEGAL_NOP_EN
      if (acc) exp_q.push_back(m[31:0]);
`else
      if (acc && !m[32]) exp_q.push_back(m[31:0]);
`endif
      if (restart && sz == 0 && !acc) exp_addr = '0;
    end
  end

  always @(negedge clk) begin
    if (rst2_n === 1'b1 && bus2.wr_en === 1'b1 && bus2.wr_ready) log2.push_back(bus2.wr_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5, input logic [20:0] imm);
    logic acc;
    bus.req_cls = cls; bus.req_rd = rd; bus.req_rs1 = rs1; bus.req_rs2 = rs2;
    bus.req_funct3 = f3; bus.req_f7b5 = f7b5; bus.req_imm = imm;
    bus.req_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    check("send_accepted", acc, 1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && (fill !== 3'd0 || bus.wr_en !== 1'b0); n++) tick();
    check("drained", {fill, bus.wr_en}, 4'd0);
  endtask

  logic [31:0] gold [6];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    gold = '{32'h00500093, 32'h0080A103, 32'h0020A223, 32'h002081B3, 32'hFE208EE3, 32'h008000EF};
    rst_n = 1'b0; rst2_n = 1'b0; restart = 1'b0; restart2 = 1'b0;
    bus.req_valid = 1'b0; bus.req_cls = '0; bus.req_rd = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
    bus.req_funct3 = '0; bus.req_f7b5 = 1'b0; bus.req_imm = '0; bus.wr_ready = 1'b1;
    bus2.req_valid = 1'b0; bus2.req_cls = 3'd4; bus2.req_rd = 5'd1; bus2.req_rs1 = '0;
    bus2.req_rs2 = '0; bus2.req_funct3 = '0; bus2.req_f7b5 = 1'b0; bus2.req_imm = 21'd1;
    bus2.wr_ready = 1'b1;
    repeat (2) tick();
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_fill", fill, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_err", err, 0);
    rst_n = 1'b1; rst2_n = 1'b1;
    tick();

    // Encoding sequence and first-word latency
    log1.delete();
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5);
    check("lat_fill", fill, 1);
    check("lat_wr_en_low", bus.wr_en, 0);
    tick();
    check("lat_wr_en_high", bus.wr_en, 1);
    check("lat_wr_data", bus.wr_data, 32'h00500093);
    send(3'd0, 5'd2, 5'd1, 5'd0, 3'd2, 1'b0, 21'd8);
    send(3'd1, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 21'd4);
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'h1FFFFC);
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd8);
    wait_drain();
    check("enc_count", log1.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("enc_addr", log1[i].addr, 32'(i * 4));
      check("enc_data", log1[i].data, gold[i]);
    end

    // Backpressure: four fill the FIFO, the fifth is held
    log1.delete();
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'(i + 1));
    bus.req_imm = 21'd5;
    bus.req_valid = 1'b1;
    repeat (3) tick();
    check("bp_fill", fill, 4);
    check("bp_req_ready", bus.req_ready, 0);
    check("bp_no_writes", log1.size(), 0);
    bus.wr_ready = 1'b1;
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5);
    wait_drain();
    check("bp_count", log1.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("bp_addr", log1[i].addr, 32'(24 + i * 4));
      check("bp_data", log1[i].data, 32'h00000093 | (32'(i + 1) << 20));
    end

    // Illegal requests
    log1.delete();
    send(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd0);
    check("ill_cls_err", err, 1);
    tick();
    check("ill_err_clears", err, 0);
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd2048);
    check("ill_imm_err", err, 1);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'd3);
    check("ill_br_err", err, 1);
    tick();
    check("ill_err_clears2", err, 0);
    repeat (4) tick();
    wait_drain();
`ifdef ENC_ILLEGAL_NOP_EN
    check("ill_nop_count", log1.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("ill_nop_addr", log1[i].addr, 32'(44 + i * 4));
      check("ill_nop_data", log1[i].data, 32'h00000013);
    end
`else
    check("ill_no_writes", log1.size(), 0);
    check("ill_fill", fill, 0);
`endif

    // Restart while idle and empty, then restart ignored while a word is pending
    log1.delete();
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd6);
    wait_drain();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd7);
    wait_drain();
    check("rs_count", log1.size(), 2);
    check("rs_addr", log1[1].addr, 0);
    log1.delete();
    bus.wr_ready = 1'b0;
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd9);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    bus.wr_ready = 1'b1;
    wait_drain();
    check("rs_ignored_addr", log1[0].addr, 4);

    // Randomized traffic checked by the negedge model
    for (int i = 0; i < 400; i++) begin
      bus.req_cls = 3'($urandom_range(0, 7));
      bus.req_rd = 5'($urandom); bus.req_rs1 = 5'($urandom); bus.req_rs2 = 5'($urandom);
      bus.req_funct3 = 3'($urandom); bus.req_f7b5 = 1'($urandom);
      case ($urandom_range(0, 3))
        0: v = int'($urandom_range(0, 127)) - 64;
        1: v = int'($urandom_range(0, 4095)) - 2048;
        2: v = int'($urandom_range(0, 10000)) - 5000;
        default: v = int'($urandom);
      endcase
      bus.req_imm = 21'(v);
      if ($urandom_range(0, 3) != 0) bus.req_imm[0] = 1'b0;
      bus.req_valid = ($urandom_range(0, 9) < 7);
      bus.wr_ready = ($urandom_range(0, 9) < 6);
      restart = ($urandom_range(0, 19) == 0);
      tick();
    end
    bus.req_valid = 1'b0;
    restart = 1'b0;
    bus.wr_ready = 1'b1;
    wait_drain();
    check("rand_model_empty", exp_q.size(), 0);

    // Address wrap with ADDR_W=4, BASE_ADDR=12
    log2.delete();
    bus2.req_valid = 1'b1;
    repeat (3) tick();
    bus2.req_valid = 1'b0;
    repeat (8) tick();
    check("wrap_count", log2.size(), 3);
    check("wrap_addr0", log2[0], 12);
    check("wrap_addr1", log2[1], 0);
    check("wrap_addr2", log2[2], 4);

    // Reset while a write is pending
    bus2.wr_ready = 1'b0;
    bus2.req_valid = 1'b1;
    repeat (2) tick();
    bus2.req_valid = 1'b0;
    for (int n = 0; n < 20 && bus2.wr_en !== 1'b1; n++) tick();
    check("mid_wr_en", bus2.wr_en, 1);
    rst2_n = 1'b0;
    tick();
    check("mid_rst_wr_en", bus2.wr_en, 0);
    check("mid_rst_fill", fill2, 0);
    check("mid_rst_addr", bus2.wr_addr, 12);
    rst2_n = 1'b1;
    bus2.wr_ready = 1'b1;
    log2.delete();
    repeat (5) tick();
    check("mid_rst_no_writes", log2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
